// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, default timing constants and parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } uart_state_e;

    localparam int unsigned OSR_DEFAULT = 16;
    localparam int unsigned FRAME_BITS  = 11;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_hold.sv
// One-entry holding register between the byte handshake and the transmit shifter.
module uart_tx_hold #(
    parameter int unsigned Width = 8
) (
    input  logic             tx_clk,
    input  logic             tx_rst_n,
    input  logic             en_i,
    input  logic [Width-1:0] wr_data_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic             drain_i,
    output logic [Width-1:0] rd_data_o,
    output logic             rd_full_o
);

    logic             full_q, full_d;
    logic [Width-1:0] data_q, data_d;

    assign wr_ready_o = en_i && !full_q;
    assign rd_data_o  = data_q;
    assign rd_full_o  = full_q;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (!en_i) begin
            full_d = 1'b0;
        end else if (wr_valid_i && wr_ready_o) begin
            full_d = 1'b1;
            data_d = wr_data_i;
        end else if (drain_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits MSB first, optional even parity, stop; OSR clocks per bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned OSR       = OSR_DEFAULT,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY_EN = 1
) (
    input  logic                   tx_clk,
    input  logic                   tx_rst_n,
    input  logic                   tx_en,
    input  logic [DATA_BITS-1:0]   tx_i_data,
    input  logic                   tx_i_data_valid,
    output logic                   tx_o_ready,
    output logic                   o_tx,
    output logic                   tx_o_busy,
    output logic                   tx_o_done,
    output logic [$clog2(OSR)-1:0] count,
    output logic [2:0]             state
);

    localparam int unsigned CW = $clog2(OSR);
    localparam int unsigned BW = $clog2(DATA_BITS);

    uart_state_e          state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shifter_q, shifter_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 drain, load, bit_end;
    logic                 hold_full;
    logic [DATA_BITS-1:0] hold_data;

    uart_tx_hold #(
        .Width (DATA_BITS)
    ) u_hold (
        .tx_clk     (tx_clk),
        .tx_rst_n   (tx_rst_n),
        .en_i       (tx_en),
        .wr_data_i  (tx_i_data),
        .wr_valid_i (tx_i_data_valid),
        .wr_ready_o (tx_o_ready),
        .drain_i    (drain),
        .rd_data_o  (hold_data),
        .rd_full_o  (hold_full)
    );

    assign bit_end = (count_q == CW'(OSR - 1));

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        bit_idx_d = bit_idx_q;
        shifter_d = shifter_q;
        parity_d  = parity_q;
        drain     = 1'b0;
        load      = 1'b0;
        if (!tx_en) begin
            state_d   = StIdle;
            count_d   = '0;
            bit_idx_d = '0;
            shifter_d = '0;
            parity_d  = 1'b0;
        end else begin
            if (state_q != StIdle) begin
                count_d = bit_end ? '0 : count_q + 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (hold_full) load = 1'b1;
                end
                StStart: begin
                    if (bit_end) begin
                        state_d   = StData;
                        bit_idx_d = '0;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        shifter_d = shifter_q << 1;
                        bit_idx_d = bit_idx_q + 1'b1;
                        if (bit_idx_q == BW'(DATA_BITS - 1)) begin
                            state_d = (PARITY_EN != 0) ? StParity : StStop;
                        end
                    end
                end
                StParity: begin
                    if (bit_end) state_d = StStop;
                end
                StStop: begin
                    // A pending byte chains straight into the next start bit.
                    if (bit_end) begin
                        if (hold_full) load = 1'b1;
                        else           state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
            if (load) begin
                shifter_d = hold_data;
                parity_d  = even_parity(hold_data);
                drain     = 1'b1;
                state_d   = StStart;
                count_d   = '0;
            end
        end
    end

    // Line level follows the next state so o_tx is registered yet changes with the state.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shifter_d[DATA_BITS-1];
            StParity: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            state_q   <= StIdle;
            count_q   <= '0;
            bit_idx_q <= '0;
            shifter_q <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            bit_idx_q <= bit_idx_d;
            shifter_q <= shifter_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
        end
    end

    assign o_tx      = tx_q;
    assign tx_o_busy = (state_q != StIdle);
    assign tx_o_done = (state_q == StStop) && bit_end;
    assign count     = count_q;
    assign state     = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame content, timing, back-to-back, enable abort, async reset.
module tb_uart_tx;

    logic       tx_clk = 1'b0;
    logic       tx_rst_n;
    logic       tx_en;
    logic [7:0] data0, data1;
    logic       valid0, valid1;
    logic       ready0, ready1, o_tx0, o_tx1, busy0, busy1, done0, done1;
    logic [3:0] count0, count1;
    logic [2:0] state0, state1;
    logic       sel;
    logic       o_tx_m, done_m;
    logic [3:0] count_m;

    int passes = 0;
    int total  = 0;

    always #5 tx_clk = ~tx_clk;

    uart_tx #(.OSR(16), .DATA_BITS(8), .PARITY_EN(1)) u0 (
        .tx_clk          (tx_clk),
        .tx_rst_n        (tx_rst_n),
        .tx_en           (tx_en),
        .tx_i_data       (data0),
        .tx_i_data_valid (valid0),
        .tx_o_ready      (ready0),
        .o_tx            (o_tx0),
        .tx_o_busy       (busy0),
        .tx_o_done       (done0),
        .count           (count0),
        .state           (state0)
    );

    uart_tx #(.OSR(16), .DATA_BITS(8), .PARITY_EN(0)) u1 (
        .tx_clk          (tx_clk),
        .tx_rst_n        (tx_rst_n),
        .tx_en           (tx_en),
        .tx_i_data       (data1),
        .tx_i_data_valid (valid1),
        .tx_o_ready      (ready1),
        .o_tx            (o_tx1),
        .tx_o_busy       (busy1),
        .tx_o_done       (done1),
        .count           (count1),
        .state           (state1)
    );

    assign o_tx_m  = sel ? o_tx1 : o_tx0;
    assign done_m  = sel ? done1 : done0;
    assign count_m = sel ? count1 : count0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input bit s, input logic [7:0] b);
        if (s) begin data1 = b; valid1 = 1'b1; end
        else   begin data0 = b; valid0 = 1'b1; end
        @(negedge tx_clk);
        valid0 = 1'b0;
        valid1 = 1'b0;
    endtask

    task automatic wait_fall(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (o_tx_m === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge tx_clk);
        end
        chk(tag, 32'(ok), 1);
    endtask

    // Entered on the first negedge where o_tx is low (cycle 1, count 0).
    task automatic capture(output logic [10:0] bits, output int done_c);
        bits   = '0;
        done_c = 0;
        for (int c = 1; c <= 200; c++) begin
            if (c > 1) @(negedge tx_clk);
            if (((c - 1) % 16) == 8) bits = {bits[9:0], o_tx_m};
            if (c == 9) chk("sample_count", 32'(count_m), 8);
            if (done_m === 1'b1) begin
                done_c = c;
                break;
            end
        end
    endtask

    task automatic quiet(input string tag, input int cycles);
        int lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge tx_clk);
            if (o_tx0 !== 1'b1 || busy0 !== 1'b0) lows++;
        end
        chk(tag, 32'(lows), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [10:0] bits;
        int          dc;
        tx_rst_n = 1'b0;
        tx_en    = 1'b1;
        data0 = 8'h00; data1 = 8'h00;
        valid0 = 1'b0; valid1 = 1'b0;
        sel = 1'b0;
        #12;
        chk("rst_o_tx", 32'(o_tx0), 1);
        chk("rst_ready", 32'(ready0), 1);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_done", 32'(done0), 0);
        chk("rst_count", 32'(count0), 0);
        chk("rst_state", 32'(state0), 0);
        @(negedge tx_clk);
        tx_rst_n = 1'b1;
        @(negedge tx_clk);

        // 0xA5: start, 10100101, parity 0, stop
        send(0, 8'hA5);
        chk("a5_latency_o_tx", 32'(o_tx0), 1);
        wait_fall("a5_fall");
        chk("a5_state_start", 32'(state0), 1);
        capture(bits, dc);
        chk("a5_bits", 32'(bits), 32'b01010010101);
        chk("a5_done_cycle", 32'(dc), 176);
        @(negedge tx_clk);
        chk("a5_idle_state", 32'(state0), 0);
        chk("a5_idle_busy", 32'(busy0), 0);

        // 0x01 with parity: parity bit 1
        send(0, 8'h01);
        wait_fall("p1_fall");
        capture(bits, dc);
        chk("p1_bits", 32'(bits), 32'b00000000111);
        chk("p1_done_cycle", 32'(dc), 176);
        @(negedge tx_clk);

        // 0x01 without parity: 10 bits, 160 cycles
        sel = 1'b1;
        send(1, 8'h01);
        wait_fall("p0_fall");
        capture(bits, dc);
        chk("p0_bits", 32'(bits), 32'b0000000011);
        chk("p0_done_cycle", 32'(dc), 160);
        sel = 1'b0;
        @(negedge tx_clk);
        @(negedge tx_clk);

        // Back-to-back 0x00 then 0xFF with valid held high
        data0  = 8'h00;
        valid0 = 1'b1;
        @(negedge tx_clk);
        chk("b2b_ready_drop", 32'(ready0), 0);
        chk("b2b_not_started", 32'(o_tx0), 1);
        data0 = 8'hFF;
        @(negedge tx_clk);
        chk("b2b_first_start", 32'(o_tx0), 0);
        chk("b2b_ready_rise", 32'(ready0), 1);
        fork
            begin
                @(negedge tx_clk);
                valid0 = 1'b0;
            end
        join_none
        capture(bits, dc);
        chk("b2b_bits0", 32'(bits), 32'b00000000001);
        chk("b2b_done0", 32'(dc), 176);
        @(negedge tx_clk);
        chk("b2b_no_gap", 32'(o_tx0), 0);
        chk("b2b_state_start", 32'(state0), 1);
        chk("b2b_count0", 32'(count0), 0);
        capture(bits, dc);
        chk("b2b_bits1", 32'(bits), 32'b01111111101);
        chk("b2b_done1", 32'(dc), 176);
        @(negedge tx_clk);
        chk("b2b_idle", 32'(state0), 0);

        // Abort 0x3C during data bit 3 with a byte pending in hold
        send(0, 8'h3C);
        wait_fall("ab_fall");
        data0  = 8'h55;
        valid0 = 1'b1;
        @(negedge tx_clk);
        valid0 = 1'b0;
        chk("ab_hold_full", 32'(ready0), 0);
        repeat (67) @(negedge tx_clk);
        chk("ab_state_data", 32'(state0), 2);
        chk("ab_count", 32'(count0), 4);
        tx_en = 1'b0;
        @(negedge tx_clk);
        chk("ab_o_tx", 32'(o_tx0), 1);
        chk("ab_state", 32'(state0), 0);
        chk("ab_ready", 32'(ready0), 0);
        chk("ab_busy", 32'(busy0), 0);
        chk("ab_count0", 32'(count0), 0);
        tx_en = 1'b1;
        @(negedge tx_clk);
        chk("ab_ready_flushed", 32'(ready0), 1);
        quiet("ab_no_spurious", 60);

        // Async reset during parity of 0x96 (parity 0)
        send(0, 8'h96);
        wait_fall("ar_fall");
        repeat (149) @(negedge tx_clk);
        chk("ar_state_parity", 32'(state0), 3);
        chk("ar_parity_low", 32'(o_tx0), 0);
        #2;
        tx_rst_n = 1'b0;
        #1;
        chk("ar_o_tx", 32'(o_tx0), 1);
        chk("ar_state", 32'(state0), 0);
        chk("ar_count", 32'(count0), 0);
        chk("ar_busy", 32'(busy0), 0);
        chk("ar_done", 32'(done0), 0);
        chk("ar_ready", 32'(ready0), 1);
        @(negedge tx_clk);
        tx_rst_n = 1'b1;
        quiet("ar_no_resume", 40);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
